usart_tx: RTL and testbench

USART_TX -- requirements
Module: usart_tx

---
 rtl/usart_pkg.sv | 19 +
 rtl/usart_baud_gen.sv | 29 ++
 rtl/usart_tx.sv | 105 ++++++++++
 tb/tb_usart_tx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM state encoding and bit-period helper.
// The PARITY state exists only when USART_TX_PARITY_EN is defined.
package usart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef USART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } usart_state_t;

   function automatic int bit_cyc(input int clock_frq, input int baud);
      return clock_frq / baud;
   endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// Bit-period timer: one-cycle tick every BIT_CYC clocks while enabled,
// reloaded on clr so each frame starts with a full bit period.
module usart_baud_gen #(
   parameter int BIT_CYC = 434
) (
   input  logic clock,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(BIT_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(BIT_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= RELOAD;
      end else if (en) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
      end
   end

   assign tick = en & (cnt == '0);

endmodule

// File: rtl/usart_tx.sv
// USART transmitter: start, UART_BIT data bits LSB first, optional even
// parity (USART_TX_PARITY_EN), one stop bit; back-to-back frames supported.
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | start bit (txd=0)
// DATA   | data bits, LSB first
// PARITY | even parity bit (USART_TX_PARITY_EN only)
// STOP   | stop bit (txd=1); last cycle may accept the next byte
module usart_tx
   import usart_pkg::*;
#(
   parameter int CLOCK_FRQ = 50_000_000,
   parameter int BADRATE   = 115_200,
   parameter int UART_BIT  = 8
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic [7:0] tx_data_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int BIT_CYC = bit_cyc(CLOCK_FRQ, BADRATE);
   localparam logic [7:0] DATA_MASK = 8'((1 << UART_BIT) - 1);

   usart_state_t state;
   logic [7:0]   shreg;
   logic [2:0]   bits_left;
   logic         tick;
   logic         accept;
`ifdef USART_TX_PARITY_EN
   logic         parity;
`endif

   usart_baud_gen #(.BIT_CYC(BIT_CYC)) u_baud (
      .clock (clock),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (tx_busy),
      .tick  (tick)
   );

   assign tx_busy  = (state != IDLE);
   assign tx_done  = (state == STOP) & tick;
   assign tx_ready = (state == IDLE) | tx_done;
   assign accept   = tx_valid & tx_ready;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         txd       <= 1'b1;
         shreg     <= '0;
         bits_left <= '0;
`ifdef USART_TX_PARITY_EN
         parity    <= 1'b0;
`endif
      end else if (accept) begin
         // acceptance wins over the STOP tick so the next start bit follows with no gap
         state     <= START;
         txd       <= 1'b0;
         shreg     <= tx_data_byte & DATA_MASK;
         bits_left <= 3'(UART_BIT - 1);
`ifdef USART_TX_PARITY_EN
         parity    <= ^(tx_data_byte & DATA_MASK);
`endif
      end else if (tick) begin
         case (state)
            START: begin
               state <= DATA;
               txd   <= shreg[0];
               shreg <= shreg >> 1;
            end
            DATA: begin
               if (bits_left == 3'd0) begin
`ifdef USART_TX_PARITY_EN
                  state <= PARITY;
                  txd   <= parity;
`else
                  state <= STOP;
                  txd   <= 1'b1;
`endif
               end else begin
                  bits_left <= bits_left - 3'd1;
                  txd       <= shreg[0];
                  shreg     <= shreg >> 1;
               end
            end
`ifdef USART_TX_PARITY_EN
            PARITY: begin
               state <= STOP;
               txd   <= 1'b1;
            end
`endif
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx at 1 MHz / 100 kbaud (10 clocks per bit); a line
// monitor decodes txd into rx_q, expected bytes go to exp_q on acceptance.
module tb_usart_tx;
   localparam int BC = 10;
   localparam int NB = 8;
`ifdef USART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (2 + NB + P) * BC;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data_byte = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, txd, tx_busy, tx_done;

   usart_tx #(.CLOCK_FRQ(1_000_000), .BADRATE(100_000), .UART_BIT(NB)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .tx_data_byte (tx_data_byte),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .txd          (txd),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [9:0] rx_q[$];   // {frame_ok, parity_bit, data}

   // Line monitor: mid-bit sampling relative to the first low negedge.
   logic       m_active = 1'b0;
   int         m_cnt, m_j;
   logic [7:0] m_byte;
   logic       m_ok, m_par;
   always @(negedge clock) begin
      if (rst_n !== 1'b1) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (txd === 1'b0) begin
            m_active = 1'b1; m_cnt = 0; m_byte = 8'h00; m_ok = 1'b1; m_par = 1'b0;
         end
      end else begin
         m_cnt++;
         if (m_cnt % BC == BC / 2) begin
            m_j = m_cnt / BC;
            if (m_j == 0) begin
               if (txd !== 1'b0) m_ok = 1'b0;
            end else if (m_j <= NB) begin
               m_byte[m_j-1] = txd;
            end else if (P == 1 && m_j == NB + 1) begin
               m_par = txd;
            end else begin
               if (txd !== 1'b1) m_ok = 1'b0;
               rx_q.push_back({m_ok, m_par, m_byte});
            end
         end
         if (m_cnt == FRAME - 1) m_active = 1'b0;
      end
   end

   task automatic send(input logic [7:0] b, output int acc);
      tx_data_byte = b;
      tx_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 4 * FRAME; i++) begin
         if (tx_ready === 1'b1) begin
            @(posedge clock);
            #1;
            acc = cyc;
            exp_q.push_back(b);
            break;
         end
         @(negedge clock);
      end
      if (acc < 0) begin
         tests_run++; tests_failed++;
         $display("FAIL send_timeout byte=%h never accepted", b);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      tests_run++;
      if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got=%b want=1", txd); end
      tests_run++;
      if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
      tests_run++;
      if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b want=0", tx_done); end
      tests_run++;
      if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_single(input logic [7:0] b);
      int acc, bp;
      logic exp_txd;
      logic [7:0] e;
      logic [9:0] got, want;
      send(b, acc);
      tx_valid = 1'b0;
      for (int k = 0; k <= FRAME; k++) begin
         @(negedge clock);
         bp = k / BC;
         if (bp == 0) exp_txd = 1'b0;
         else if (bp <= NB) exp_txd = b[bp-1];
         else if (P == 1 && bp == NB + 1) exp_txd = ^b;
         else exp_txd = 1'b1;
         tests_run++;
         if (txd !== exp_txd) begin
            tests_failed++;
            $display("FAIL single_txd byte=%h k=%0d got=%b want=%b", b, k, txd, exp_txd);
         end
         tests_run++;
         if (tx_done !== 1'(k == FRAME - 1)) begin
            tests_failed++;
            $display("FAIL single_done byte=%h k=%0d got=%b want=%b", b, k, tx_done, k == FRAME - 1);
         end
         tests_run++;
         if (tx_busy !== 1'(k < FRAME)) begin
            tests_failed++;
            $display("FAIL single_busy byte=%h k=%0d got=%b want=%b", b, k, tx_busy, k < FRAME);
         end
      end
      tests_run++;
      if (rx_q.size() != 1 || exp_q.size() != 1) begin
         tests_failed++;
         $display("FAIL single_rxcount got=%0d want=1", rx_q.size());
      end else begin
         e = exp_q.pop_front();
         got = rx_q.pop_front();
         want = {1'b1, (P == 1) ? ^e : 1'b0, e};
         if (got !== want) begin
            tests_failed++;
            $display("FAIL single_rx got=%h want=%h", got, want);
         end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_back_to_back();
      int a1, a2, done_cyc;
      logic [7:0] e;
      logic [9:0] got;
      send(8'hA5, a1);
      send(8'h3C, a2);
      tx_valid = 1'b0;
      tests_run++;
      if (a2 - a1 != FRAME) begin
         tests_failed++;
         $display("FAIL b2b_gap got=%0d want=%0d", a2 - a1, FRAME);
      end
      @(negedge clock);
      tests_run++;
      if (txd !== 1'b0) begin tests_failed++; $display("FAIL b2b_start got=%b want=0", txd); end
      done_cyc = -1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (tx_done === 1'b1) begin done_cyc = cyc; break; end
         @(negedge clock);
      end
      tests_run++;
      if (done_cyc != a1 + 2 * FRAME - 1) begin
         tests_failed++;
         $display("FAIL b2b_total got=%0d want=%0d", done_cyc - a1 + 1, 2 * FRAME);
      end
      repeat (2) @(negedge clock);
      tests_run++;
      if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got=%b want=0", tx_busy); end
      tests_run++;
      if (rx_q.size() != 2 || exp_q.size() != 2) begin
         tests_failed++;
         $display("FAIL b2b_rxcount got=%0d want=2", rx_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            got = rx_q.pop_front();
            tests_run++;
            if (got[7:0] !== e || got[9] !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_rx idx=%0d got=%h want=%h", i, got, e);
            end
         end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_reset_abort();
      int acc, rel, acc2, dones;
      logic [9:0] got;
      send(8'hF0, acc);
      tx_valid = 1'b0;
      for (int k = 0; k <= BC + 4 * BC + BC / 2; k++) @(negedge clock);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (txd !== 1'b1) begin tests_failed++; $display("FAIL abort_txd got=%b want=1", txd); end
      tests_run++;
      if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b want=0", tx_busy); end
      tests_run++;
      if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b want=0", tx_done); end
      exp_q.delete();
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      rel = cyc;
      tests_run++;
      if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got=%b want=1", tx_ready); end
      send(8'h81, acc2);
      tx_valid = 1'b0;
      tests_run++;
      if (acc2 != rel + 1) begin
         tests_failed++;
         $display("FAIL abort_first_accept got=%0d want=%0d", acc2 - rel, 1);
      end
      dones = 0;
      for (int k = 0; k < FRAME + 5; k++) begin
         @(negedge clock);
         if (tx_done === 1'b1) dones++;
      end
      tests_run++;
      if (dones != 1) begin tests_failed++; $display("FAIL abort_done_count got=%0d want=1", dones); end
      tests_run++;
      if (rx_q.size() != 1) begin
         tests_failed++;
         $display("FAIL abort_rxcount got=%0d want=1", rx_q.size());
      end else begin
         got = rx_q.pop_front();
         if (got[7:0] !== 8'h81 || got[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_rx got=%h want=81", got);
         end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_ignore();
      int acc;
      logic [9:0] got;
      send(8'h00, acc);
      tx_valid = 1'b0;
      repeat (30) @(negedge clock);
      tests_run++;
      if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL ignore_ready got=%b want=0", tx_ready); end
      tx_data_byte = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      repeat (3 * FRAME) @(negedge clock);
      tests_run++;
      if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_idle got=%b want=0", tx_busy); end
      tests_run++;
      if (rx_q.size() != 1) begin
         tests_failed++;
         $display("FAIL ignore_rxcount got=%0d want=1", rx_q.size());
      end else begin
         got = rx_q.pop_front();
         if (got[7:0] !== 8'h00 || got[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_rx got=%h want=00", got);
         end
      end
      exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_loopback();
      int acc;
      logic [7:0] e;
      logic [9:0] got;
      for (int b = 0; b < 256; b++) send(8'(b), acc);
      tx_valid = 1'b0;
      repeat (FRAME + 5) @(negedge clock);
      tests_run++;
      if (rx_q.size() != 256 || exp_q.size() != 256) begin
         tests_failed++;
         $display("FAIL loop_rxcount got=%0d want=256", rx_q.size());
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = rx_q.pop_front();
         tests_run++;
         if (got !== {1'b1, (P == 1) ? ^e : 1'b0, e}) begin
            tests_failed++;
            $display("FAIL loop_rx got=%h want=%h", got[7:0], e);
         end
      end
      exp_q.delete(); rx_q.delete();
   endtask

`ifdef USART_TX_PARITY_EN
   task automatic test_parity();
      int acc;
      logic [9:0] got;
      send(8'h07, acc);
      send(8'h03, acc);
      tx_valid = 1'b0;
      repeat (FRAME + 5) @(negedge clock);
      tests_run++;
      if (rx_q.size() != 2) begin
         tests_failed++;
         $display("FAIL parity_rxcount got=%0d want=2", rx_q.size());
      end else begin
         got = rx_q.pop_front();
         tests_run++;
         if (got[8] !== 1'b1) begin tests_failed++; $display("FAIL parity_07 got=%b want=1", got[8]); end
         got = rx_q.pop_front();
         tests_run++;
         if (got[8] !== 1'b0) begin tests_failed++; $display("FAIL parity_03 got=%b want=0", got[8]); end
      end
      exp_q.delete(); rx_q.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_single(8'h55);
      test_single(8'h07);
      test_single(8'h03);
      test_back_to_back();
      test_reset_abort();
      test_ignore();
      test_loopback();
`ifdef USART_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
